// File: rtl/conv_encoder_frame.sv
// rtl/conv_encoder_frame.sv - frame-based rate-1/2 K=3 (7/5) convolutional encoder with zero tail
module conv_encoder_frame #(
   parameter int FRAME_BITS = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [FRAME_BITS-1:0] i_data,
   input  logic                  i_valid,
   output logic                  o_ready,
   output logic [1:0]            o_code,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic                  o_last
);

   localparam int CW = $clog2(FRAME_BITS + 2);
   localparam logic [CW-1:0] LAST_DATA = CW'(FRAME_BITS - 1);
   localparam logic [CW-1:0] FIRST_TAIL = CW'(FRAME_BITS);
   localparam int MSB = FRAME_BITS - 1;

   typedef enum logic [1:0] {
      IDLE,
      ENCODE,
      FLUSH
   } state_t;

   state_t                  state, state_nx;
   logic [FRAME_BITS-1:0]   sr, sr_nx;
   logic [1:0]              trel, trel_nx;
   logic [CW-1:0]           cnt, cnt_nx;
   logic [1:0]              code_nx;
   logic                    valid_nx;
   logic                    last_nx;

   // Trellis after the presented bit, and the symbol for the bit that follows it.
   // The shift register back-fills with zeros, so once all payload bits have gone
   // the bit behind the MSB is 0 and the tail symbols fall out naturally.
   logic [1:0]              trel_adv;
   logic [1:0]              code_adv;

   // Rate-1/2 generator pair: c1 = u^s1^s0 (g=111), c0 = u^s0 (g=101).
   function automatic logic [1:0] enc(input logic u, input logic [1:0] s);
      return {u ^ s[1] ^ s[0], u ^ s[0]};
   endfunction

   assign o_ready  = (state == IDLE) && !rst;
   assign trel_adv = {sr[MSB], trel[1]};
   assign code_adv = enc(sr[MSB-1], trel_adv);

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Datapath and registered output symbol
   always_ff @(posedge clk) begin
      if (rst) begin
         sr      <= '0;
         trel    <= 2'b00;
         cnt     <= '0;
         o_code  <= 2'b00;
         o_valid <= 1'b0;
         o_last  <= 1'b0;
      end else begin
         sr      <= sr_nx;
         trel    <= trel_nx;
         cnt     <= cnt_nx;
         o_code  <= code_nx;
         o_valid <= valid_nx;
         o_last  <= last_nx;
      end
   end

   // Next-state and next-symbol logic; everything holds unless a handshake occurs
   always_comb begin
      state_nx = state;
      sr_nx    = sr;
      trel_nx  = trel;
      cnt_nx   = cnt;
      code_nx  = o_code;
      valid_nx = o_valid;
      last_nx  = o_last;
      case (state)
         IDLE: begin
            if (i_valid) begin
               state_nx = ENCODE;
               sr_nx    = i_data;
               trel_nx  = 2'b00;
               cnt_nx   = '0;
               code_nx  = enc(i_data[MSB], 2'b00);
               valid_nx = 1'b1;
               last_nx  = 1'b0;
            end
         end
         ENCODE: begin
            if (i_ready) begin
               sr_nx   = {sr[MSB-1:0], 1'b0};
               trel_nx = trel_adv;
               cnt_nx  = cnt + CW'(1);
               code_nx = code_adv;
               last_nx = 1'b0;
               if (cnt == LAST_DATA) begin
                  state_nx = FLUSH;
               end
            end
         end
         FLUSH: begin
            if (i_ready) begin
               sr_nx   = {sr[MSB-1:0], 1'b0};
               trel_nx = trel_adv;
               if (cnt == FIRST_TAIL) begin
                  cnt_nx  = cnt + CW'(1);
                  code_nx = code_adv;
                  last_nx = 1'b1;
               end else begin
                  state_nx = IDLE;
                  code_nx  = 2'b00;
                  valid_nx = 1'b0;
                  last_nx  = 1'b0;
               end
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_conv_encoder_frame.sv
// tb/tb_conv_encoder_frame.sv - randomized self-checking bench for conv_encoder_frame
module tb_conv_encoder_frame;

   localparam int FB = 8;
   localparam int NS = FB + 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [FB-1:0] i_data = '0;
   logic          i_valid = 1'b0;
   logic          i_ready = 1'b1;
   logic          o_ready;
   logic [1:0]    o_code;
   logic          o_valid;
   logic          o_last;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   bit armed = 0;
   bit after_rst = 0;
   bit rand_ready = 0;

   logic [1:0] expq[$];
   logic [1:0] cap[$];
   int         acc_cyc[$];

   localparam logic [2*NS-1:0] SEQ_B0 = 20'b11_10_00_01_01_11_00_00_00_00;
   localparam logic [2*NS-1:0] SEQ_FF = 20'b11_01_10_10_10_10_10_10_01_11;
   localparam logic [2*NS-1:0] SEQ_00 = 20'b00_00_00_00_00_00_00_00_00_00;

   always #5 clk = ~clk;

   conv_encoder_frame #(.FRAME_BITS(FB)) dut (
      .clk(clk),
      .rst(rst),
      .i_data(i_data),
      .i_valid(i_valid),
      .o_ready(o_ready),
      .o_code(o_code),
      .o_valid(o_valid),
      .i_ready(i_ready),
      .o_last(o_last)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Whole-frame code sequence, first symbol in the top bits, from the generator rules.
   function automatic logic [2*NS-1:0] model_frame(input logic [FB-1:0] d);
      logic [2*NS-1:0] r;
      logic u, s1, s0;
      r = '0;
      s1 = 1'b0;
      s0 = 1'b0;
      for (int k = 0; k < NS; k++) begin
         u = (k < FB) ? d[FB-1-k] : 1'b0;
         r = {r[2*NS-3:0], u ^ s1 ^ s0, u ^ s0};
         s0 = s1;
         s1 = u;
      end
      return r;
   endfunction

   function automatic logic [2*NS-1:0] cap_word(input int start);
      logic [2*NS-1:0] r;
      r = '0;
      for (int k = 0; k < NS; k++) begin
         r = {r[2*NS-3:0], cap[start+k]};
      end
      return r;
   endfunction

   // Per-cycle compare against the queue of outstanding expected symbols
   always @(negedge clk) begin
      logic [2*NS-1:0] w;
      cyc++;
      if (armed) begin
         check("o_ready", o_ready, (!rst && expq.size() == 0));
         check("o_valid", o_valid, (expq.size() != 0));
         if (expq.size() != 0) begin
            check("o_code", o_code, expq[0]);
            check("o_last", o_last, (expq.size() == 1));
         end else if (after_rst) begin
            check("rst_o_code", o_code, 2'b00);
            check("rst_o_last", o_last, 1'b0);
         end
      end
      if (rst) begin
         expq.delete();
         armed = 1;
         after_rst = 1;
      end else if (armed) begin
         if (o_valid && i_ready && expq.size() != 0) begin
            cap.push_back(o_code);
            void'(expq.pop_front());
         end
         if (o_ready && i_valid) begin
            w = model_frame(i_data);
            for (int k = 0; k < NS; k++) expq.push_back(w[2*NS-1-2*k -: 2]);
            acc_cyc.push_back(cyc);
            after_rst = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_ready) i_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic send_frame(input logic [FB-1:0] d);
      bit ok;
      ok = 0;
      i_valid = 1'b1;
      i_data = d;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (o_ready) begin
            ok = 1;
            break;
         end
         tick();
      end
      if (!ok) check("accept_timeout", 0, 1);
      tick();
      i_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (o_ready) begin
            tick();
            return;
         end
         tick();
      end
      check("idle_timeout", 0, 1);
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;

      check("model_b0", model_frame(8'b1011_0000), SEQ_B0);
      check("model_ff", model_frame(8'hFF), SEQ_FF);
      check("model_00", model_frame(8'h00), SEQ_00);

      // Basic frame
      cap.delete();
      send_frame(8'b1011_0000);
      wait_idle();
      check("s1_count", cap.size(), NS);
      if (cap.size() == NS) check("s1_seq", cap_word(0), SEQ_B0);

      // All ones followed by all zeros proves the trellis returned to 00
      cap.delete();
      send_frame(8'hFF);
      wait_idle();
      send_frame(8'h00);
      wait_idle();
      check("s2_count", cap.size(), 2 * NS);
      if (cap.size() == 2 * NS) begin
         check("s2_seq_ff", cap_word(0), SEQ_FF);
         check("s2_seq_00", cap_word(NS), SEQ_00);
      end

      // Stall three cycles on the fourth symbol
      cap.delete();
      send_frame(8'b1011_0000);
      repeat (3) tick();
      i_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("s3_hold_code", o_code, 2'b01);
         check("s3_hold_valid", o_valid, 1'b1);
         tick();
      end
      i_ready = 1'b1;
      @(negedge clk);
      check("s3_hold_code", o_code, 2'b01);
      wait_idle();
      check("s3_count", cap.size(), NS);
      if (cap.size() == NS) check("s3_seq", cap_word(0), SEQ_B0);

      // Back-to-back frames with i_valid held high
      cap.delete();
      i_valid = 1'b1;
      i_data = 8'hFF;
      send_frame(8'hFF);
      i_valid = 1'b1;
      i_data = 8'h00;
      send_frame(8'h00);
      wait_idle();
      check("s4_period", acc_cyc[acc_cyc.size()-1] - acc_cyc[acc_cyc.size()-2], NS + 1);
      check("s4_count", cap.size(), 2 * NS);
      if (cap.size() == 2 * NS) begin
         check("s4_seq_ff", cap_word(0), SEQ_FF);
         check("s4_seq_00", cap_word(NS), SEQ_00);
      end

      // Reset during the fifth symbol abandons the frame
      send_frame(8'hFF);
      repeat (4) tick();
      @(negedge clk);
      check("s5_pre_code", o_code, 2'b10);
      rst = 1'b1;
      tick();
      @(negedge clk);
      check("s5_rst_valid", o_valid, 1'b0);
      check("s5_rst_last", o_last, 1'b0);
      check("s5_rst_code", o_code, 2'b00);
      check("s5_rst_ready", o_ready, 1'b0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("s5_ready_after", o_ready, 1'b1);
      tick();
      cap.delete();
      send_frame(8'b1011_0000);
      wait_idle();
      check("s5_count", cap.size(), NS);
      if (cap.size() == NS) check("s5_seq", cap_word(0), SEQ_B0);

      // New data offered mid-frame must be ignored
      cap.delete();
      send_frame(8'b1011_0000);
      tick();
      i_valid = 1'b1;
      i_data = 8'h5A;
      repeat (2) tick();
      i_valid = 1'b0;
      wait_idle();
      check("s6_count", cap.size(), NS);
      if (cap.size() == NS) check("s6_seq", cap_word(0), SEQ_B0);

      // Random payloads under random backpressure
      rand_ready = 1;
      for (int f = 0; f < 25; f++) begin
         send_frame(FB'($urandom));
         if ($urandom_range(0, 2) == 0) begin
            tick();
            i_valid = 1'b1;
            i_data = FB'($urandom);
            tick();
            i_valid = 1'b0;
         end
         wait_idle();
         repeat ($urandom_range(0, 2)) tick();
      end
      rand_ready = 0;
      i_ready = 1'b1;
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
